vliw_scoreboard: RTL and testbench
==================================

VLIW_SCOREBOARD -- requirements
Module: vliw_scoreboard

Interface
REQ-001 Parameter CNT_W, default 32, is the width of the stall cycle counter.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rstn  in  1  reset: synchronous, active-low.
REQ-004 bundle_valid  in  1  a 4-slot bundle is presented at decode this cycle.
REQ-005 slot_valid1..4  in  1 each  slot k holds a real instruction (not a nop).
REQ-006 srca1..4, srcb1..4  in  6 each  source register addresses {concat bit, 5-bit field}; 6'd0 means no dependency.
REQ-007 dst1..4  in  6 each  destination register address of slot k.
REQ-008 dst_we1..4  in  1 each  slot k writes dst k.
REQ-009 wb_we1..4  in  1 each  write port k retires a write this cycle (ports 1,2 from M; ports 3,4 from W).
REQ-010 wb_reg1..4  in  6 each  register written by port k.
REQ-011 drain_req  in  1  request to stop issue and wait for all writes to retire.
REQ-012 stall  out  1  combinational; holds the bundle in decode.
REQ-013 issue  out  1  combinational; bundle accepted this cycle.
REQ-014 busy  out  64  registered pending-write bit per register.
REQ-015 drain_done  out  1  registered; drain complete.
REQ-016 stall_cnt  out  CNT_W  registered count of stalled bundle cycles.
REQ-017 bundle_err  out  1  registered sticky; two slots in one bundle wrote the same register.
REQ-018 wb_err  out  1  registered sticky; a write retired to a non-busy register.

Function
REQ-019 Effective clear mask clr = OR over k of (wb_we k and wb_reg k != 0) decoded to 64 bits.
REQ-020 Register r is hazardous when busy[r]=1 and clr[r]=0; a same-cycle retire removes the hazard (write-through bypass).
REQ-021 Slot k is blocked if slot_valid k=1 and any of srca k, srcb k (RAW) or dst k with dst_we k=1 (WAW) is nonzero and hazardous.
REQ-022 stall = bundle_valid and (any slot blocked or state != RUN).
REQ-023 issue = bundle_valid and not stall; a bundle is only issued whole, never split by slot.
REQ-024 Set mask set = OR over k of (issue and slot_valid k and dst_we k and dst k != 0) decoded to 64 bits.
REQ-025 Next busy = (busy and not clr) or set; set wins over clr on the same register in the same cycle.
REQ-026 busy[0] is held at 0 permanently.
REQ-027 wb_err sets when wb_we k=1, wb_reg k != 0 and busy[wb_reg k]=0; busy is unchanged for that register.
REQ-028 bundle_err sets when an issued bundle has two or more slots with dst_we=1 and the same nonzero dst; busy still sets for that register.
REQ-029 stall_cnt increments by 1 each cycle bundle_valid and stall are both 1, and saturates at all-ones.
REQ-030 FSM states: RUN, DRAIN, DONE.
REQ-031 RUN -> DRAIN when drain_req=1; issue is still allowed in that same cycle.
REQ-032 DRAIN -> DONE on the first cycle where next busy is all zero; drain_done=1 only in DONE.
REQ-033 DONE -> RUN on the cycle drain_req=0; DRAIN with drain_req dropped continues to DONE before returning to RUN.
REQ-034 Drain with busy already zero reaches DONE on the cycle after drain_req is sampled.

Reset
REQ-035 On a clk edge with rstn=0: busy=0, state=RUN, drain_done=0, stall_cnt=0, bundle_err=0, wb_err=0.
REQ-036 rstn asserted mid-drain or with writes pending discards all pending state.
REQ-037 No write retires to the scoreboard during reset.

Verification
REQ-038 Issue slot1 dst=6'd5 we=1 -> busy[5]=1 next cycle; the next bundle with srca2=5 gives stall=1 and stall_cnt+1 per cycle until wb_we1 with wb_reg1=5 -> issue=1 in that same cycle.
REQ-039 busy[7]=1, wb_we3 with wb_reg3=7, and an issued bundle with dst4=7 we=1 in the same cycle -> busy[7] remains 1, no stall.
REQ-040 Issued bundle with dst1=dst2=6'd9, both we=1 -> bundle_err=1 sticky, busy[9]=1.
REQ-041 srca/dst=0 in all slots with busy all set except bit 0 -> no stall; busy[0] stays 0.
REQ-042 busy[3]=busy[40]=1, pulse drain_req -> stall=1; retire 3 then 40 -> drain_done=1 the cycle after 40 retires; RUN again after drain_req=0.
REQ-043 wb_we2 with wb_reg2=12 while busy[12]=0 -> wb_err=1; rstn=0 for one cycle -> all outputs return to their reset values.

Source files
------------

// File: rtl/vliw_scoreboard.sv
// Register scoreboard for a 4-slot VLIW decode stage.
// Tracks one pending-write bit per register, stalls whole bundles on RAW/WAW
// hazards with a same-cycle retire bypass, and supports a drain handshake.
module vliw_scoreboard #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             bundle_valid,
    input  logic             slot_valid1,
    input  logic             slot_valid2,
    input  logic             slot_valid3,
    input  logic             slot_valid4,
    input  logic [5:0]       srca1,
    input  logic [5:0]       srca2,
    input  logic [5:0]       srca3,
    input  logic [5:0]       srca4,
    input  logic [5:0]       srcb1,
    input  logic [5:0]       srcb2,
    input  logic [5:0]       srcb3,
    input  logic [5:0]       srcb4,
    input  logic [5:0]       dst1,
    input  logic [5:0]       dst2,
    input  logic [5:0]       dst3,
    input  logic [5:0]       dst4,
    input  logic             dst_we1,
    input  logic             dst_we2,
    input  logic             dst_we3,
    input  logic             dst_we4,
    input  logic             wb_we1,
    input  logic             wb_we2,
    input  logic             wb_we3,
    input  logic             wb_we4,
    input  logic [5:0]       wb_reg1,
    input  logic [5:0]       wb_reg2,
    input  logic [5:0]       wb_reg3,
    input  logic [5:0]       wb_reg4,
    input  logic             drain_req,
    output logic             stall,
    output logic             issue,
    output logic [63:0]      busy,
    output logic             drain_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             bundle_err,
    output logic             wb_err
);

    typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

    state_e      state_q;
    logic [63:0] busy_q;
    logic [63:0] busy_d;
    logic [63:0] clr;
    logic [63:0] set;
    logic [63:0] hazard;
    logic [3:0]  sv;
    logic [3:0]  dwe;
    logic [3:0]  wwe;
    logic [3:0]  blocked;
    logic [3:0]  writes;
    logic        dup_dst;
    logic        wb_bad;
    logic [5:0]  sa [4];
    logic [5:0]  sb [4];
    logic [5:0]  dd [4];
    logic [5:0]  wr [4];

    assign sv  = {slot_valid4, slot_valid3, slot_valid2, slot_valid1};
    assign dwe = {dst_we4, dst_we3, dst_we2, dst_we1};
    assign wwe = {wb_we4, wb_we3, wb_we2, wb_we1};
    assign sa[0] = srca1;
    assign sa[1] = srca2;
    assign sa[2] = srca3;
    assign sa[3] = srca4;
    assign sb[0] = srcb1;
    assign sb[1] = srcb2;
    assign sb[2] = srcb3;
    assign sb[3] = srcb4;
    assign dd[0] = dst1;
    assign dd[1] = dst2;
    assign dd[2] = dst3;
    assign dd[3] = dst4;
    assign wr[0] = wb_reg1;
    assign wr[1] = wb_reg2;
    assign wr[2] = wb_reg3;
    assign wr[3] = wb_reg4;

    // Decode this cycle's retiring writes into a clear mask.
    always_comb begin
        clr = '0;
        for (int k = 0; k < 4; k++) begin
            if (wwe[k] && wr[k] != 6'd0) clr[wr[k]] = 1'b1;
        end
    end

    // A retire in the same cycle bypasses the hazard.
    assign hazard = busy_q & ~clr;

    // Per-slot RAW/WAW blocking and which slots would write a real register.
    always_comb begin
        blocked = '0;
        writes  = '0;
        for (int k = 0; k < 4; k++) begin
            writes[k]  = sv[k] && dwe[k] && dd[k] != 6'd0;
            blocked[k] = sv[k] && ((sa[k] != 6'd0 && hazard[sa[k]]) ||
                                   (sb[k] != 6'd0 && hazard[sb[k]]) ||
                                   (writes[k] && hazard[dd[k]]));
        end
    end

    assign stall = bundle_valid && ((|blocked) || state_q != StRun);
    assign issue = bundle_valid && !stall;

    // Set mask from the issued bundle plus duplicate-destination detection.
    always_comb begin
        set     = '0;
        dup_dst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (issue && writes[k]) set[dd[k]] = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (issue && writes[i] && writes[j] && dd[i] == dd[j]) dup_dst = 1'b1;
            end
        end
    end

    // Flag any retire that targets a register with no pending write.
    always_comb begin
        wb_bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (wwe[k] && wr[k] != 6'd0 && !busy_q[wr[k]]) wb_bad = 1'b1;
        end
    end

    // Set wins over clear; register 0 never becomes busy.
    assign busy_d = ((busy_q & ~clr) | set) & ~64'd1;
    assign busy   = busy_q;

    // Scoreboard bits, stall counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q     <= '0;
            stall_cnt  <= '0;
            bundle_err <= 1'b0;
            wb_err     <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (dup_dst) bundle_err <= 1'b1;
            if (wb_bad) wb_err <= 1'b1;
        end
    end

    // Drain handshake FSM with registered done flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StRun;
            drain_done <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (drain_req) state_q <= StDrain;
                end
                StDrain: begin
                    if (busy_d == '0) begin
                        state_q    <= StDone;
                        drain_done <= 1'b1;
                    end
                end
                StDone: begin
                    if (!drain_req) begin
                        state_q    <= StRun;
                        drain_done <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StRun;
                    drain_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vliw_scoreboard.sv
// Self-checking bench for vliw_scoreboard: directed scenarios plus a randomized
// run checked against a set-of-pending-registers reference model.
module tb_vliw_scoreboard;

    localparam int unsigned CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int M_RUN = 0;
    localparam int M_DRAIN = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic bundle_valid = 1'b0;
    logic drain_req = 1'b0;
    logic t_sv [4];
    logic t_dwe [4];
    logic t_wwe [4];
    logic [5:0] t_sa [4];
    logic [5:0] t_sb [4];
    logic [5:0] t_dst [4];
    logic [5:0] t_wr [4];

    logic stall, issue, drain_done, bundle_err, wb_err;
    logic [63:0] busy;
    logic [CW-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail = 0;

    // Reference model: which registers have a write in flight, drain phase, counters.
    bit pend [64];
    int phase = M_RUN;
    int cnt = 0;
    bit m_berr = 1'b0;
    bit m_werr = 1'b0;
    logic exp_stall, exp_issue, obs_stall, obs_issue;

    vliw_scoreboard #(.CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .bundle_valid(bundle_valid),
        .slot_valid1(t_sv[0]), .slot_valid2(t_sv[1]),
        .slot_valid3(t_sv[2]), .slot_valid4(t_sv[3]),
        .srca1(t_sa[0]), .srca2(t_sa[1]), .srca3(t_sa[2]), .srca4(t_sa[3]),
        .srcb1(t_sb[0]), .srcb2(t_sb[1]), .srcb3(t_sb[2]), .srcb4(t_sb[3]),
        .dst1(t_dst[0]), .dst2(t_dst[1]), .dst3(t_dst[2]), .dst4(t_dst[3]),
        .dst_we1(t_dwe[0]), .dst_we2(t_dwe[1]), .dst_we3(t_dwe[2]), .dst_we4(t_dwe[3]),
        .wb_we1(t_wwe[0]), .wb_we2(t_wwe[1]), .wb_we3(t_wwe[2]), .wb_we4(t_wwe[3]),
        .wb_reg1(t_wr[0]), .wb_reg2(t_wr[1]), .wb_reg3(t_wr[2]), .wb_reg4(t_wr[3]),
        .drain_req(drain_req), .stall(stall), .issue(issue), .busy(busy),
        .drain_done(drain_done), .stall_cnt(stall_cnt),
        .bundle_err(bundle_err), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    function automatic bit retiring(input logic [5:0] r);
        for (int k = 0; k < 4; k++) begin
            if (t_wwe[k] && t_wr[k] != 6'd0 && t_wr[k] == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit hazardous(input logic [5:0] r);
        return r != 6'd0 && pend[r] && !retiring(r);
    endfunction

    function automatic bit model_stall();
        if (!bundle_valid) return 1'b0;
        if (phase != M_RUN) return 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (t_sv[k] && (hazardous(t_sa[k]) || hazardous(t_sb[k]) ||
                            (t_dwe[k] && hazardous(t_dst[k])))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [63:0] model_busy();
        logic [63:0] v;
        for (int r = 0; r < 64; r++) v[r] = pend[r];
        return v;
    endfunction

    task automatic model_update(input bit iss);
        bit nxt [64];
        bit any;
        if (!rstn) begin
            foreach (pend[r]) pend[r] = 1'b0;
            phase = M_RUN;
            cnt = 0;
            m_berr = 1'b0;
            m_werr = 1'b0;
            return;
        end
        if (bundle_valid && !iss && cnt < CNT_MAX) cnt++;
        for (int k = 0; k < 4; k++) begin
            if (t_wwe[k] && t_wr[k] != 6'd0 && !pend[t_wr[k]]) m_werr = 1'b1;
        end
        if (iss) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = i + 1; j < 4; j++) begin
                    if (t_sv[i] && t_dwe[i] && t_sv[j] && t_dwe[j] &&
                        t_dst[i] != 6'd0 && t_dst[i] == t_dst[j]) m_berr = 1'b1;
                end
            end
        end
        nxt = pend;
        for (int k = 0; k < 4; k++) begin
            if (t_wwe[k] && t_wr[k] != 6'd0) nxt[t_wr[k]] = 1'b0;
        end
        if (iss) begin
            for (int k = 0; k < 4; k++) begin
                if (t_sv[k] && t_dwe[k] && t_dst[k] != 6'd0) nxt[t_dst[k]] = 1'b1;
            end
        end
        pend = nxt;
        any = 1'b0;
        foreach (pend[r]) if (pend[r]) any = 1'b1;
        case (phase)
            M_RUN:   if (drain_req) phase = M_DRAIN;
            M_DRAIN: if (!any) phase = M_DONE;
            default: if (!drain_req) phase = M_RUN;
        endcase
    endtask

    // One clock: sample combinational outputs at the falling edge, advance the
    // model, then return 1 time unit after the rising edge.
    task automatic step();
        @(negedge clk);
        exp_stall = model_stall();
        exp_issue = bundle_valid && !exp_stall;
        obs_stall = stall;
        obs_issue = issue;
        model_update(exp_issue);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rstn = 1'b1;
        bundle_valid = 1'b0;
        drain_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            t_sv[k] = 1'b0; t_dwe[k] = 1'b0; t_wwe[k] = 1'b0;
            t_sa[k] = 6'd0; t_sb[k] = 6'd0; t_dst[k] = 6'd0; t_wr[k] = 6'd0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        n_tests++; if (busy !== 64'd0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy); end
        n_tests++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", drain_done); end
        n_tests++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        n_tests++; if (bundle_err !== 1'b0) begin n_fail++; $display("FAIL reset_berr: got %b want 0", bundle_err); end
        n_tests++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL reset_werr: got %b want 0", wb_err); end
    endtask

    task automatic test_raw_stall();
        do_reset();
        bundle_valid = 1'b1;
        t_sv[0] = 1'b1; t_dst[0] = 6'd5; t_dwe[0] = 1'b1;
        step();
        n_tests++; if (obs_issue !== 1'b1) begin n_fail++; $display("FAIL raw_first_issue: got %b want 1", obs_issue); end
        n_tests++; if (busy[5] !== 1'b1) begin n_fail++; $display("FAIL raw_busy5: got %b want 1", busy[5]); end
        clear_inputs();
        bundle_valid = 1'b1;
        t_sv[1] = 1'b1; t_sa[1] = 6'd5;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_tests++; if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b want 1", obs_stall); end
            n_tests++; if (stall_cnt !== CW'(i)) begin n_fail++; $display("FAIL raw_cnt: got %0d want %0d", stall_cnt, i); end
        end
        t_wwe[0] = 1'b1; t_wr[0] = 6'd5;
        step();
        n_tests++; if (obs_issue !== 1'b1) begin n_fail++; $display("FAIL raw_bypass_issue: got %b want 1", obs_issue); end
        n_tests++; if (stall_cnt !== 4'd3) begin n_fail++; $display("FAIL raw_cnt_hold: got %0d want 3", stall_cnt); end
        n_tests++; if (busy[5] !== 1'b0) begin n_fail++; $display("FAIL raw_busy5_clr: got %b want 0", busy[5]); end
    endtask

    task automatic test_set_wins();
        do_reset();
        bundle_valid = 1'b1;
        t_sv[0] = 1'b1; t_dst[0] = 6'd7; t_dwe[0] = 1'b1;
        step();
        clear_inputs();
        bundle_valid = 1'b1;
        t_sv[3] = 1'b1; t_dst[3] = 6'd7; t_dwe[3] = 1'b1;
        t_wwe[2] = 1'b1; t_wr[2] = 6'd7;
        step();
        n_tests++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL setwin_stall: got %b want 0", obs_stall); end
        n_tests++; if (busy[7] !== 1'b1) begin n_fail++; $display("FAIL setwin_busy7: got %b want 1", busy[7]); end
    endtask

    task automatic test_bundle_err();
        do_reset();
        bundle_valid = 1'b1;
        t_sv[0] = 1'b1; t_dst[0] = 6'd9; t_dwe[0] = 1'b1;
        t_sv[1] = 1'b1; t_dst[1] = 6'd9; t_dwe[1] = 1'b1;
        step();
        n_tests++; if (bundle_err !== 1'b1) begin n_fail++; $display("FAIL berr_set: got %b want 1", bundle_err); end
        n_tests++; if (busy[9] !== 1'b1) begin n_fail++; $display("FAIL berr_busy9: got %b want 1", busy[9]); end
        clear_inputs();
        t_wwe[0] = 1'b1; t_wr[0] = 6'd9;
        step();
        n_tests++; if (bundle_err !== 1'b1) begin n_fail++; $display("FAIL berr_sticky: got %b want 1", bundle_err); end
        n_tests++; if (busy[9] !== 1'b0) begin n_fail++; $display("FAIL berr_busy9_clr: got %b want 0", busy[9]); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        for (int b = 0; b < 16; b++) begin
            clear_inputs();
            bundle_valid = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (b * 4 + k + 1 <= 63) begin
                    t_sv[k] = 1'b1; t_dwe[k] = 1'b1; t_dst[k] = 6'(b * 4 + k + 1);
                end
            end
            step();
        end
        n_tests++; if (busy !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL zero_fill: got %h want fffffffffffffffe", busy); end
        clear_inputs();
        bundle_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin t_sv[k] = 1'b1; t_dwe[k] = 1'b1; end
        step();
        n_tests++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %b want 0", obs_stall); end
        n_tests++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL zero_busy0: got %b want 0", busy[0]); end
    endtask

    task automatic test_drain();
        do_reset();
        bundle_valid = 1'b1;
        t_sv[0] = 1'b1; t_dst[0] = 6'd3; t_dwe[0] = 1'b1;
        t_sv[1] = 1'b1; t_dst[1] = 6'd40; t_dwe[1] = 1'b1;
        step();
        clear_inputs();
        bundle_valid = 1'b1; t_sv[0] = 1'b1; drain_req = 1'b1;
        step();
        n_tests++; if (obs_issue !== 1'b1) begin n_fail++; $display("FAIL drain_req_issue: got %b want 1", obs_issue); end
        drain_req = 1'b0;
        step();
        n_tests++; if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL drain_stall: got %b want 1", obs_stall); end
        t_wwe[0] = 1'b1; t_wr[0] = 6'd3;
        step();
        n_tests++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL drain_early: got %b want 0", drain_done); end
        t_wr[0] = 6'd40;
        step();
        n_tests++; if (drain_done !== 1'b1) begin n_fail++; $display("FAIL drain_done: got %b want 1", drain_done); end
        t_wwe[0] = 1'b0;
        step();
        n_tests++; if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL done_stall: got %b want 1", obs_stall); end
        n_tests++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL done_exit: got %b want 0", drain_done); end
        step();
        n_tests++; if (obs_issue !== 1'b1) begin n_fail++; $display("FAIL run_again_issue: got %b want 1", obs_issue); end
        // Drain with nothing pending: DRAIN then DONE, held while drain_req stays high.
        do_reset();
        drain_req = 1'b1;
        step();
        n_tests++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL empty_drain1: got %b want 0", drain_done); end
        step();
        n_tests++; if (drain_done !== 1'b1) begin n_fail++; $display("FAIL empty_drain2: got %b want 1", drain_done); end
        step();
        n_tests++; if (drain_done !== 1'b1) begin n_fail++; $display("FAIL empty_hold: got %b want 1", drain_done); end
        drain_req = 1'b0;
        step();
        n_tests++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL empty_release: got %b want 0", drain_done); end
    endtask

    task automatic test_saturation();
        do_reset();
        bundle_valid = 1'b1;
        t_sv[0] = 1'b1; t_dst[0] = 6'd20; t_dwe[0] = 1'b1;
        step();
        clear_inputs();
        bundle_valid = 1'b1; t_sv[1] = 1'b1; t_sb[1] = 6'd20;
        for (int i = 0; i < 14; i++) step();
        n_tests++; if (stall_cnt !== 4'd14) begin n_fail++; $display("FAIL sat_pre: got %0d want 14", stall_cnt); end
        for (int i = 0; i < 6; i++) step();
        n_tests++; if (stall_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_hold: got %0d want 15", stall_cnt); end
    endtask

    task automatic test_wb_err_reset();
        do_reset();
        bundle_valid = 1'b1;
        t_sv[0] = 1'b1; t_dst[0] = 6'd33; t_dwe[0] = 1'b1;
        step();
        clear_inputs();
        t_wwe[1] = 1'b1; t_wr[1] = 6'd12;
        step();
        n_tests++; if (wb_err !== 1'b1) begin n_fail++; $display("FAIL werr_set: got %b want 1", wb_err); end
        n_tests++; if (busy !== 64'h2_0000_0000) begin n_fail++; $display("FAIL werr_busy: got %h want 200000000", busy); end
        clear_inputs();
        drain_req = 1'b1;
        step();
        clear_inputs();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        n_tests++; if (busy !== 64'd0) begin n_fail++; $display("FAIL rst2_busy: got %h want 0", busy); end
        n_tests++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL rst2_werr: got %b want 0", wb_err); end
        n_tests++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL rst2_done: got %b want 0", drain_done); end
        bundle_valid = 1'b1; t_sv[0] = 1'b1;
        step();
        n_tests++; if (obs_issue !== 1'b1) begin n_fail++; $display("FAIL rst2_run: got %b want 1", obs_issue); end
    endtask

    task automatic test_random();
        int q[$];
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            q.delete();
            foreach (pend[r]) if (pend[r]) q.push_back(r);
            rstn = ($urandom_range(999) < 5) ? 1'b0 : 1'b1;
            bundle_valid = ($urandom_range(3) != 0);
            drain_req = ($urandom_range(99) < 3);
            for (int k = 0; k < 4; k++) begin
                t_sv[k] = ($urandom_range(9) < 6);
                t_sa[k] = 6'($urandom_range(15));
                t_sb[k] = 6'($urandom_range(15));
                t_dst[k] = 6'($urandom_range(15));
                t_dwe[k] = 1'($urandom_range(1));
                t_wwe[k] = 1'b0;
                t_wr[k] = 6'd0;
                if (rstn && q.size() > 0 && $urandom_range(99) < 35) begin
                    t_wwe[k] = 1'b1;
                    t_wr[k] = 6'(q[$urandom_range(q.size() - 1)]);
                end else if (rstn && $urandom_range(99) < 3) begin
                    t_wwe[k] = 1'b1;
                    t_wr[k] = 6'($urandom_range(63));
                end
            end
            step();
            n_tests++; if (obs_stall !== exp_stall) begin n_fail++; $display("FAIL rand_stall @%0d: got %b want %b", i, obs_stall, exp_stall); end
            n_tests++; if (obs_issue !== exp_issue) begin n_fail++; $display("FAIL rand_issue @%0d: got %b want %b", i, obs_issue, exp_issue); end
            n_tests++; if (busy !== model_busy()) begin n_fail++; $display("FAIL rand_busy @%0d: got %h want %h", i, busy, model_busy()); end
            n_tests++; if (drain_done !== (phase == M_DONE)) begin n_fail++; $display("FAIL rand_done @%0d: got %b want %b", i, drain_done, phase == M_DONE); end
            n_tests++; if (stall_cnt !== CW'(cnt)) begin n_fail++; $display("FAIL rand_cnt @%0d: got %0d want %0d", i, stall_cnt, cnt); end
            n_tests++; if (bundle_err !== m_berr) begin n_fail++; $display("FAIL rand_berr @%0d: got %b want %b", i, bundle_err, m_berr); end
            n_tests++; if (wb_err !== m_werr) begin n_fail++; $display("FAIL rand_werr @%0d: got %b want %b", i, wb_err, m_werr); end
        end
        rstn = 1'b1;
    endtask

    initial begin
        foreach (pend[r]) pend[r] = 1'b0;
        clear_inputs();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_raw_stall();
        test_set_wins();
        test_bundle_err();
        test_zero_reg();
        test_drain();
        test_saturation();
        test_wb_err_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
